// File: rtl/conv_layer_pkg.sv
// Shared state codes, controller phases and width helper for the conv-layer
// input buffer, kernel and sequencer.
package conv_layer_pkg;

  localparam logic [2:0] STATE_IDLE  = 3'd0;
  localparam logic [2:0] STATE_LOAD  = 3'd1;
  localparam logic [2:0] STATE_SHIFT = 3'd2;
  localparam logic [2:0] STATE_BIAS  = 3'd3;

  typedef enum logic [2:0] {
    P_IDLE,
    P_PRELOAD,
    P_SHIFT,
    P_BIAS,
    P_LOAD
  } phase_t;

  // Index width that never collapses to zero bits for tiny dimensions.
  function automatic int clog2_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_layer_wrap_counter.sv
// Modulo-MOD up-counter with enable and synchronous clear; wrap pulses on the
// enabled cycle that rolls the count from MOD-1 back to 0.
module conv_layer_wrap_counter #(
  parameter int MOD = 8,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = en && (count == W'(MOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/conv_layer_input_ctrl.sv
// Sequencer for the conv-layer input row buffer: preload rows, sweep the
// kernel window, one bias cycle, stream the next row, until the frame ends.
module conv_layer_input_ctrl
  import conv_layer_pkg::*;
#(
  parameter int BUFFER_ROW  = 3,
  parameter int BUFFER_COL  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int IMAGE_ROW   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [2:0]                         current_state,
  output logic [clog2_w(BUFFER_COL)-1:0]     col_index,
  output logic [clog2_w(BUFFER_ROW)-1:0]     row_index,
  output logic [clog2_w(BUFFER_ROW)-1:0]     preload_cycle,
  output logic [clog2_w(BUFFER_COL)-1:0]     shift_index,
  output logic                               window_valid,
  output logic                               row_done,
  output logic                               busy,
  output logic                               done
);

  localparam int CW     = clog2_w(BUFFER_COL);
  localparam int RW     = clog2_w(BUFFER_ROW);
  localparam int NW     = clog2_w(IMAGE_ROW + 1);
  localparam int NSHIFT = BUFFER_COL - KERNEL_SIZE + 1;

  phase_t          phase;
  logic [NW-1:0]   rows_used;
  logic            word_acc;
  logic            start_acc;
  logic            col_wrap;
  logic            row_wrap;
  logic            shift_wrap;
  logic            in_shift;
  logic            win_clr;

  assign in_ready     = (phase == P_PRELOAD) || (phase == P_LOAD);
  assign word_acc     = in_valid && in_ready;
  assign start_acc    = start && (phase == P_IDLE) && !busy;
  assign in_shift     = (phase == P_SHIFT);
  assign window_valid = in_shift;
  assign row_done     = (phase == P_BIAS);
  assign win_clr      = start_acc || ((phase == P_LOAD) && col_wrap);

  // LOAD is only presented with a word in hand: the buffer shifts its rows on
  // any LOAD cycle at column 0, so a stalled word must not repeat it.
  always_comb begin
    current_state = STATE_IDLE;
    case (phase)
      P_PRELOAD, P_LOAD: if (word_acc) current_state = STATE_LOAD;
      P_SHIFT:           current_state = STATE_SHIFT;
      P_BIAS:            current_state = STATE_BIAS;
      default:           current_state = STATE_IDLE;
    endcase
  end

  conv_layer_wrap_counter #(.MOD(BUFFER_COL), .W(CW)) u_col (
    .clk(clk), .rst(rst), .en(word_acc), .clr(start_acc),
    .count(col_index), .wrap(col_wrap)
  );

  conv_layer_wrap_counter #(.MOD(BUFFER_ROW), .W(RW)) u_row (
    .clk(clk), .rst(rst), .en(in_shift), .clr(win_clr),
    .count(row_index), .wrap(row_wrap)
  );

  conv_layer_wrap_counter #(.MOD(NSHIFT), .W(CW)) u_shift (
    .clk(clk), .rst(rst), .en(in_shift && row_wrap), .clr(win_clr),
    .count(shift_index), .wrap(shift_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase         <= P_IDLE;
      preload_cycle <= '0;
      rows_used     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (done) busy <= 1'b0;
      case (phase)
        P_IDLE: begin
          if (start_acc) begin
            phase         <= P_PRELOAD;
            preload_cycle <= '0;
            rows_used     <= '0;
            busy          <= 1'b1;
          end
        end
        P_PRELOAD: begin
          if (col_wrap) begin
            rows_used <= rows_used + 1'b1;
            if (preload_cycle == RW'(BUFFER_ROW - 1)) phase <= P_SHIFT;
            else preload_cycle <= preload_cycle + 1'b1;
          end
        end
        P_SHIFT: begin
          if (shift_wrap) phase <= P_BIAS;
        end
        P_BIAS: begin
          if (rows_used < NW'(IMAGE_ROW)) begin
            phase <= P_LOAD;
          end else begin
            phase <= P_IDLE;
            done  <= 1'b1;
          end
        end
        P_LOAD: begin
          if (col_wrap) begin
            rows_used <= rows_used + 1'b1;
            phase     <= P_SHIFT;
          end
        end
        default: phase <= P_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_input_ctrl.sv
// Directed bench for conv_layer_input_ctrl: default geometry plus a
// single-window, single-pass geometry (KERNEL_SIZE = BUFFER_COL, IMAGE_ROW = 3).
module tb_conv_layer_input_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, in_valid_a, start_b, in_valid_b;

  logic       a_ready, a_wv, a_rd, a_busy, a_done;
  logic [2:0] a_state, a_col, a_shift;
  logic [1:0] a_row, a_pre;

  logic       b_ready, b_wv, b_rd, b_busy, b_done;
  logic [2:0] b_state, b_col, b_shift;
  logic [1:0] b_row, b_pre;

  int n_chk  = 0;
  int n_fail = 0;
  int words_a = 0;
  int rd_a    = 0;
  int exp_col = 0;

  always #5 clk = ~clk;

  conv_layer_input_ctrl dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid_a),
    .in_ready(a_ready), .current_state(a_state), .col_index(a_col),
    .row_index(a_row), .preload_cycle(a_pre), .shift_index(a_shift),
    .window_valid(a_wv), .row_done(a_rd), .busy(a_busy), .done(a_done)
  );

  conv_layer_input_ctrl #(.KERNEL_SIZE(8), .IMAGE_ROW(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid_b),
    .in_ready(b_ready), .current_state(b_state), .col_index(b_col),
    .row_index(b_row), .preload_cycle(b_pre), .shift_index(b_shift),
    .window_valid(b_wv), .row_done(b_rd), .busy(b_busy), .done(b_done)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Buffer-side scoreboard: every LOAD must carry the next column in sequence,
  // so column 0 can only reappear after column 7 of the previous row.
  always @(negedge clk) begin
    if (rst) begin
      exp_col = 0;
    end else begin
      if (a_state == 3'd1) begin
        check_val("load_col_seq", int'(a_col), exp_col);
        exp_col = (exp_col + 1) % 8;
        words_a++;
      end
      if (a_rd) rd_a++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_a(input string tag);
    check_val({tag, "_state"}, int'(a_state), 0);
    check_val({tag, "_ready"}, int'(a_ready), 0);
    check_val({tag, "_col"},   int'(a_col),   0);
    check_val({tag, "_row"},   int'(a_row),   0);
    check_val({tag, "_pre"},   int'(a_pre),   0);
    check_val({tag, "_shift"}, int'(a_shift), 0);
    check_val({tag, "_wv"},    int'(a_wv),    0);
    check_val({tag, "_rd"},    int'(a_rd),    0);
    check_val({tag, "_busy"},  int'(a_busy),  0);
    check_val({tag, "_done"},  int'(a_done),  0);
  endtask

  task automatic run_preload_a();
    for (int k = 0; k < 24; k++) begin
      in_valid_a = 1'b1;
      #1;
      check_val("pre_state", int'(a_state), 1);
      check_val("pre_col",   int'(a_col),   k % 8);
      check_val("pre_cycle", int'(a_pre),   k / 8);
      check_val("pre_ready", int'(a_ready), 1);
      check_val("pre_busy",  int'(a_busy),  1);
      cyc();
    end
  endtask

  task automatic run_shift_a(input bit poke);
    for (int j = 0; j < 18; j++) begin
      start_a = (poke && j == 4);
      #1;
      check_val("sh_state", int'(a_state), 2);
      check_val("sh_row",   int'(a_row),   j % 3);
      check_val("sh_shift", int'(a_shift), j / 3);
      check_val("sh_wv",    int'(a_wv),    1);
      check_val("sh_ready", int'(a_ready), 0);
      check_val("sh_pre",   int'(a_pre),   2);
      check_val("sh_busy",  int'(a_busy),  1);
      cyc();
    end
    start_a = 1'b0;
  endtask

  task automatic check_bias_a();
    #1;
    check_val("bias_state", int'(a_state), 3);
    check_val("bias_rd",    int'(a_rd),    1);
    check_val("bias_wv",    int'(a_wv),    0);
    check_val("bias_done",  int'(a_done),  0);
    check_val("bias_row",   int'(a_row),   0);
    check_val("bias_shift", int'(a_shift), 0);
    cyc();
  endtask

  task automatic run_load_a(input bit toggle);
    int acc = 0;
    int n = 0;
    bit v;
    while (acc < 8 && n < 40) begin
      v = toggle ? (n % 2 == 0) : 1'b1;
      in_valid_a = v;
      #1;
      check_val("ld_state", int'(a_state), v ? 1 : 0);
      check_val("ld_col",   int'(a_col),   acc);
      check_val("ld_ready", int'(a_ready), 1);
      if (v) acc++;
      n++;
      cyc();
    end
    check_val("ld_words", acc, 8);
    check_val("ld_cycles", n, toggle ? 15 : 8);
    in_valid_a = 1'b1;
  endtask

  initial begin
    int w0;
    int r0;
    rst = 1'b1;
    start_a = 1'b0; in_valid_a = 1'b0;
    start_b = 1'b0; in_valid_b = 1'b0;
    #12;
    check_idle_a("rst");
    cyc();
    rst = 1'b0;
    cyc();
    check_idle_a("post_rst");

    // Full frame, default geometry; start poked mid-SHIFT, in_valid toggled on the first load.
    w0 = words_a; r0 = rd_a;
    start_a = 1'b1; in_valid_a = 1'b1;
    #1;
    check_val("idle_vld_state", int'(a_state), 0);
    check_val("idle_vld_ready", int'(a_ready), 0);
    cyc();
    start_a = 1'b0;
    run_preload_a();
    run_shift_a(1'b1);
    check_bias_a();
    for (int p = 1; p <= 5; p++) begin
      run_load_a(p == 1);
      run_shift_a(1'b0);
      check_bias_a();
    end
    #1;
    check_val("fin_done",  int'(a_done),  1);
    check_val("fin_busy",  int'(a_busy),  1);
    check_val("fin_state", int'(a_state), 0);
    check_val("fin_ready", int'(a_ready), 0);
    cyc();
    check_val("after_done", int'(a_done), 0);
    check_val("after_busy", int'(a_busy), 0);
    check_val("frame_words",   words_a - w0, 64);
    check_val("frame_row_done", rd_a - r0, 6);

    // Reset in the middle of a LOAD row.
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    run_preload_a();
    run_shift_a(1'b0);
    check_bias_a();
    for (int k = 0; k < 4; k++) begin
      in_valid_a = 1'b1;
      #1;
      check_val("mid_col", int'(a_col), k);
      cyc();
    end
    #1;
    check_val("mid_col4", int'(a_col), 4);
    rst = 1'b1;
    #1;
    check_idle_a("async_rst");
    cyc();
    rst = 1'b0;
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    run_preload_a();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    in_valid_a = 1'b0;

    // Single-window, single-pass geometry.
    start_b = 1'b1; in_valid_b = 1'b1;
    cyc();
    start_b = 1'b0;
    for (int k = 0; k < 24; k++) begin
      #1;
      check_val("b_pre_state", int'(b_state), 1);
      check_val("b_pre_col",   int'(b_col),   k % 8);
      check_val("b_pre_cycle", int'(b_pre),   k / 8);
      check_val("b_pre_ready", int'(b_ready), 1);
      cyc();
    end
    for (int j = 0; j < 3; j++) begin
      #1;
      check_val("b_sh_state", int'(b_state), 2);
      check_val("b_sh_row",   int'(b_row),   j);
      check_val("b_sh_shift", int'(b_shift), 0);
      check_val("b_sh_wv",    int'(b_wv),    1);
      cyc();
    end
    #1;
    check_val("b_bias_state", int'(b_state), 3);
    check_val("b_bias_rd",    int'(b_rd),    1);
    check_val("b_bias_done",  int'(b_done),  0);
    cyc();
    check_val("b_fin_done",  int'(b_done),  1);
    check_val("b_fin_busy",  int'(b_busy),  1);
    check_val("b_fin_state", int'(b_state), 0);
    check_val("b_fin_rd",    int'(b_rd),    0);
    cyc();
    check_val("b_after_done",  int'(b_done),  0);
    check_val("b_after_busy",  int'(b_busy),  0);
    check_val("b_after_ready", int'(b_ready), 0);
    check_val("b_after_col",   int'(b_col),   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_layer_input_ctrl.md
Name: conv_layer_input_ctrl

Overview:
- Sequencer for the conv-layer input row buffer (BUFFER_ROW x BUFFER_COL words of DATA_WIDTH).
- Drives the buffer's current_state, col_index, row_index and preload_cycle inputs, and accepts input pixels through a valid/ready handshake.
- Sequence: preload BUFFER_ROW rows, sweep the kernel window across the buffered rows, run one bias cycle, stream in the next image row, repeat until all image rows are consumed.

Parameters:
- BUFFER_ROW, 3, rows held in the buffer; equals kernel height.
- BUFFER_COL, 8, words per buffered row; equals image width.
- KERNEL_SIZE, 3, kernel width in words; must be <= BUFFER_COL.
- IMAGE_ROW, 8, total input rows per frame; must be >= BUFFER_ROW.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse: begin a frame; ignored unless idle
- in_valid  in  1  input pixel valid
- in_ready  out  1  controller accepts a pixel this cycle
- current_state  out  3  buffer state code (package encoding)
- col_index  out  CW=clog2(BUFFER_COL)  write column for the incoming pixel
- row_index  out  RW=clog2(BUFFER_ROW)  buffer row selected for readout
- preload_cycle  out  RW  count of rows loaded during preload
- shift_index  out  CW  leftmost column of the current kernel window
- window_valid  out  1  data_out_bus holds row row_index of window shift_index
- row_done  out  1  one-cycle pulse in the BIAS cycle
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last BIAS of the frame

Behaviour:
- Widths: CW = max(1, clog2(BUFFER_COL)); RW = max(1, clog2(BUFFER_ROW)).
- Reset: all outputs 0; current_state = STATE_IDLE; internal phase = P_IDLE. Reset has immediate effect at any point, including mid-frame; no partial row survives it.
- Internal phases: P_IDLE, P_PRELOAD, P_SHIFT, P_BIAS, P_LOAD. Registered phase and counters. current_state and in_ready are combinational from the phase and in_valid.
- in_ready = 1 in P_PRELOAD and P_LOAD only.
- Accepted word: in_valid & in_ready.
- current_state = STATE_LOAD only on cycles with an accepted word. Otherwise, in P_PRELOAD and P_LOAD, it is STATE_IDLE. Reason: the buffer shifts rows on every LOAD cycle where col_index == 0, so LOAD is never held while a word is stalled.
- Outside the load phases, current_state follows the phase: P_SHIFT gives STATE_SHIFT, P_BIAS gives STATE_BIAS, P_IDLE gives STATE_IDLE.
- col_index: increments on each accepted word and wraps BUFFER_COL-1 -> 0. A wrap ends the row. It holds on in_valid = 0 and holds in the non-load phases.
- P_IDLE -> P_PRELOAD on start. This clears all counters and sets busy = 1.
- P_PRELOAD: preload_cycle increments at each row end. At the end of row BUFFER_ROW-1, go to P_SHIFT; preload_cycle then holds BUFFER_ROW-1 until the next start.
- P_SHIFT lasts (BUFFER_COL-KERNEL_SIZE+1)*BUFFER_ROW cycles; window_valid = 1 throughout.
  - row_index steps 0..BUFFER_ROW-1 every cycle.
  - shift_index increments when row_index wraps.
  - After the last row of the last window, go to P_BIAS.
- P_BIAS: exactly one cycle, with row_done = 1.
  - If rows consumed < IMAGE_ROW, go to P_LOAD.
  - Otherwise go to P_IDLE, with done = 1 on that same cycle and busy = 0 on the next.
- P_LOAD: stream one row of BUFFER_COL words, then go to P_SHIFT with row_index and shift_index reset to 0.
- Rows consumed counter: width clog2(IMAGE_ROW+1); increments at each row end.
- Output rows per frame: IMAGE_ROW-BUFFER_ROW+1.
- start while busy: ignored, with no effect on counters.
- in_valid outside the load phases: ignored (in_ready = 0).
- Edge case IMAGE_ROW == BUFFER_ROW: exactly one SHIFT/BIAS pass, then done.
- Edge case KERNEL_SIZE == BUFFER_COL: exactly one window per row.

Decomposition:
- Shared package conv_layer_pkg holds:
  - state codes STATE_IDLE = 3'd0, STATE_LOAD = 3'd1, STATE_SHIFT = 3'd2, STATE_BIAS = 3'd3;
  - the phase enum;
  - the clog2 width helper.
  The existing buffer and kernel consume the same state codes.
- One sub-module: conv_layer_wrap_counter (parameterised modulo counter with enable, clear and a wrap pulse). Instanced for col_index, row_index and shift_index.

Test Plan:
- Defaults, in_valid held at 1, start at cycle 0:
  - preload takes 24 accepted words, with col_index 0..7 repeated 3 times and preload_cycle 0 -> 2;
  - then 18 SHIFT cycles, with shift_index 0..5 and row_index cycling 0,1,2;
  - then row_done.
- Same run to completion: 6 row_done pulses; done one cycle after the 6th BIAS; 64 words accepted in total; busy drops.
- in_valid toggled 1,0,1,0 during P_LOAD: current_state = STATE_LOAD only on the 1-cycles; col_index holds through the 0-cycles; the row completes after 8 accepted words.
- Scoreboard buffer model: STATE_LOAD with col_index = 0 is never asserted twice within the same row.
- start pulsed during P_SHIFT: no change to counters, phase or busy.
- rst asserted in P_LOAD at col_index = 4:
  - all outputs return to 0 and current_state to STATE_IDLE immediately;
  - a new start restarts the preload with preload_cycle = 0.
- IMAGE_ROW = 3, KERNEL_SIZE = 8: 24 words, then 3 SHIFT cycles with shift_index held at 0, then a single BIAS and done.
